// File: rtl/boot_copy_arbiter.sv
// Boot-time flash-to-RAM byte copier that then hands the data bus to the CPU.
// Optional checksum output boot_sum is enabled by defining BOOT_CHECKSUM_EN.
`ifndef FLASH_INIT
`define FLASH_INIT 32'h1000_0000
`endif
`ifndef RAM_INIT
`define RAM_INIT 32'h2000_0000
`endif

module boot_copy_arbiter #(
  parameter int unsigned COPY_LEN  = 260,
  parameter logic [31:0] SRC_BASE  = `FLASH_INIT,
  parameter logic [31:0] DST_BASE  = `RAM_INIT,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_rw,
  input  logic [1:0]           cpu_len,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_ack,
  output logic                 cpu_err,
  output logic                 bus_rw,
  output logic [1:0]           bus_len,
  output logic [31:0]          bus_addr,
  output logic [31:0]          bus_wdata,
  input  logic [31:0]          bus_rdata,
  input  logic                 bus_exception,
  output logic                 boot_done,
  output logic                 boot_error,
`ifdef BOOT_CHECKSUM_EN
  output logic [31:0]          boot_sum,
`endif
  output logic [CNT_WIDTH-1:0] copy_count
);

  typedef enum logic [2:0] {C_RD, C_WAIT, C_WR, IDLE, CPU_ACC, ERR} state_t;

  state_t                 state, state_d;
  logic                   rw_d, ack_d, err_d, done_d, berr_d;
  logic [1:0]             len_d;
  logic [31:0]            addr_d, wdata_d, rdata_d, count_ext;
  logic [CNT_WIDTH-1:0]   count_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]            sum_d;
`endif

  assign count_ext = 32'(copy_count);

  always_comb begin
    state_d = state;
    rw_d    = bus_rw;
    len_d   = bus_len;
    addr_d  = bus_addr;
    wdata_d = bus_wdata;
    ack_d   = 1'b0;
    err_d   = cpu_err;
    rdata_d = cpu_rdata;
    done_d  = boot_done;
    berr_d  = boot_error;
    count_d = copy_count;
`ifdef BOOT_CHECKSUM_EN
    sum_d   = boot_sum;
`endif
    case (state)
      C_RD: begin
        rw_d = 1'b0;
        if (COPY_LEN == 0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          addr_d  = SRC_BASE + count_ext;
          state_d = C_WAIT;
        end
      end
      C_WAIT: begin
        if (bus_exception) begin
          state_d = ERR;
          berr_d  = 1'b1;
          done_d  = 1'b0;
          rw_d    = 1'b0;
        end else begin
          wdata_d = {24'h0, bus_rdata[7:0]};
          addr_d  = DST_BASE + count_ext;
          rw_d    = 1'b1;
          state_d = C_WR;
`ifdef BOOT_CHECKSUM_EN
          sum_d   = boot_sum + {24'h0, bus_rdata[7:0]};
`endif
        end
      end
      C_WR: begin
        rw_d = 1'b0;
        if (bus_exception) begin
          state_d = ERR;
          berr_d  = 1'b1;
          done_d  = 1'b0;
        end else begin
          count_d = copy_count + CNT_WIDTH'(1);
          if (count_ext + 32'd1 == 32'(COPY_LEN)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = C_RD;
          end
        end
      end
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          rw_d    = cpu_rw;
          len_d   = cpu_len;
          wdata_d = cpu_wdata;
          state_d = CPU_ACC;
        end else begin
          rw_d = 1'b0;
        end
      end
      CPU_ACC: begin
        ack_d   = 1'b1;
        rdata_d = bus_rdata;
        err_d   = bus_exception;
        rw_d    = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        rw_d   = 1'b0;
        berr_d = 1'b1;
        done_d = 1'b0;
      end
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= C_RD;
      bus_rw     <= 1'b0;
      bus_len    <= 2'b00;
      bus_addr   <= SRC_BASE;
      bus_wdata  <= 32'h0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= 32'h0;
      boot_done  <= 1'b0;
      boot_error <= 1'b0;
      copy_count <= '0;
`ifdef BOOT_CHECKSUM_EN
      boot_sum   <= 32'h0;
`endif
    end else begin
      state      <= state_d;
      bus_rw     <= rw_d;
      bus_len    <= len_d;
      bus_addr   <= addr_d;
      bus_wdata  <= wdata_d;
      cpu_ack    <= ack_d;
      cpu_err    <= err_d;
      cpu_rdata  <= rdata_d;
      boot_done  <= done_d;
      boot_error <= berr_d;
      copy_count <= count_d;
`ifdef BOOT_CHECKSUM_EN
      boot_sum   <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_boot_copy_arbiter.sv
// Bench for boot_copy_arbiter: random flash images, injected bus exceptions and
// random CPU traffic against a byte-array reference of the RAM contents.
module tb_boot_copy_arbiter;

  localparam int unsigned LEN = 4;
  localparam logic [31:0] SRC = 32'h1000_0000;
  localparam logic [31:0] DST = 32'h2000_0000;
  localparam logic [31:0] EXC_RAM = DST + 32'd40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req = 1'b0, cpu_rw = 1'b0;
  logic [1:0]  cpu_len = 2'b00;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata, bus_addr, bus_wdata, bus_rdata;
  logic        cpu_ack, cpu_err, bus_rw, bus_exception, boot_done, boot_error;
  logic [1:0]  bus_len;
  logic [15:0] copy_count;

  logic        cpu_req0 = 1'b0;
  logic [31:0] cpu_rdata0, bus_addr0, bus_wdata0;
  logic        cpu_ack0, cpu_err0, bus_rw0, boot_done0, boot_error0;
  logic [1:0]  bus_len0;
  logic [15:0] copy_count0;
  logic [31:0] bus_rdata0;
  assign bus_rdata0 = 32'hC0DE_0042;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] boot_sum, boot_sum0;
`endif

  boot_copy_arbiter #(.COPY_LEN(LEN), .SRC_BASE(SRC), .DST_BASE(DST), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_len(cpu_len),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_err(cpu_err), .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_exception(bus_exception),
    .boot_done(boot_done), .boot_error(boot_error),
`ifdef BOOT_CHECKSUM_EN
    .boot_sum(boot_sum),
`endif
    .copy_count(copy_count));

  boot_copy_arbiter #(.COPY_LEN(0), .SRC_BASE(SRC), .DST_BASE(DST), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req0), .cpu_rw(1'b0), .cpu_len(2'b00),
    .cpu_addr(DST), .cpu_wdata(32'h0), .cpu_rdata(cpu_rdata0), .cpu_ack(cpu_ack0),
    .cpu_err(cpu_err0), .bus_rw(bus_rw0), .bus_len(bus_len0), .bus_addr(bus_addr0),
    .bus_wdata(bus_wdata0), .bus_rdata(bus_rdata0), .bus_exception(1'b0),
    .boot_done(boot_done0), .boot_error(boot_error0),
`ifdef BOOT_CHECKSUM_EN
    .boot_sum(boot_sum0),
`endif
    .copy_count(copy_count0));

  // Environment memory: flash image (bench-owned) and RAM written only by the bus.
  logic [7:0]  flash_mem [0:255];
  logic [7:0]  ram_mem   [0:255];
  logic [7:0]  ref_ram   [0:255];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx = 8'h0, ld_val = 8'h0;
  logic        exc_en = 1'b0;
  logic [31:0] exc_addr = 32'h0;
  logic [31:0] off_f, off_r;
  int          rw0_cnt = 0;

  always_comb begin
    off_f = '0;
    off_r = '0;
    bus_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      off_f = bus_addr + 32'(i) - SRC;
      off_r = bus_addr + 32'(i) - DST;
      if (off_f < 32'd256) bus_rdata[8*i +: 8] = flash_mem[off_f[7:0]];
      else if (off_r < 32'd256) bus_rdata[8*i +: 8] = ram_mem[off_r[7:0]];
    end
  end

  assign bus_exception = exc_en && !bus_rw && (bus_addr == exc_addr);

  always @(posedge clk) begin
    if (ld_en) ram_mem[ld_idx] <= ld_val;
    else if (bus_rw)
      for (int i = 0; i < 4; i++)
        if (i < ((bus_len == 2'd0) ? 1 : (bus_len == 2'd1) ? 2 : 4) &&
            (bus_addr + 32'(i) - DST) < 32'd256)
          ram_mem[8'(bus_addr + 32'(i) - DST)] <= bus_wdata[8*i +: 8];
  end

  always @(posedge clk) if (bus_rw0) rw0_cnt <= rw0_cnt + 1;

  int checks = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if (a - SRC < 32'd256) return flash_mem[8'(a - SRC)];
    if (a - DST < 32'd256) return ref_ram[8'(a - DST)];
    return 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_byte(a + 32'd3), ref_byte(a + 32'd2), ref_byte(a + 32'd1), ref_byte(a)};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_addr"}, bus_addr, SRC);
    check({tag, "_rw"}, 32'(bus_rw), 0);
    check({tag, "_len"}, 32'(bus_len), 0);
    check({tag, "_wdata"}, bus_wdata, 0);
    check({tag, "_ack"}, 32'(cpu_ack), 0);
    check({tag, "_err"}, 32'(cpu_err), 0);
    check({tag, "_rdata"}, cpu_rdata, 0);
    check({tag, "_done"}, 32'(boot_done), 0);
    check({tag, "_berr"}, 32'(boot_error), 0);
    check({tag, "_count"}, 32'(copy_count), 0);
`ifdef BOOT_CHECKSUM_EN
    check({tag, "_sum"}, boot_sum, 0);
`endif
  endtask

  // One CPU access from IDLE; the ack must land two edges after the request.
  task automatic cpu_op(input logic rw, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] wdata);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat, nb;
    exp_rdata = ref_word(addr);
    exp_err   = exc_en && !rw && (addr == exc_addr);
    cpu_req = 1'b1; cpu_rw = rw; cpu_len = len; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      lat = n;
      if (cpu_ack) break;
    end
    check("cpu_latency", lat, 2);
    check("cpu_rdata", cpu_rdata, exp_rdata);
    check("cpu_err", 32'(cpu_err), 32'(exp_err));
    cpu_req = 1'b0;
    nb = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    if (rw) for (int i = 0; i < nb; i++) ref_ram[8'(addr + 32'(i) - DST)] = wdata[8*i +: 8];
  endtask

  initial begin
    int cyc, early_ack, exc_byte, copied, acks, sel, lat;
    logic [31:0] exp_sum;

    for (int i = 0; i < 256; i++) flash_mem[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_init");
    check("len0_rst_done", 32'(boot_done0), 0);
    ld_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_idx = 8'(i); ld_val = 8'($urandom); ref_ram[i] = ld_val;
      @(posedge clk); #1;
    end
    ld_en = 1'b0;

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(LEN); i++) flash_mem[i] = 8'($urandom);
      exc_byte = (r == 1) ? 2 : (r == 3) ? int'($urandom_range(0, 4)) : int'(LEN);
      exc_en   = 1'b1;
      exc_addr = (exc_byte < int'(LEN)) ? SRC + 32'(exc_byte) : EXC_RAM;

      if (r == 2) begin
        @(negedge clk) rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("abort_count", 32'(copy_count), 2);
        rst_n = 1'b0;
        #1;
        check("abort_rst_count", 32'(copy_count), 0);
        check("abort_rst_addr", bus_addr, SRC);
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_len = 2'b00; cpu_addr = DST + 32'd2;
      end

      @(negedge clk) rst_n = 1'b1;
      cyc = 0; early_ack = 0;
      for (int c = 1; c <= 200; c++) begin
        @(posedge clk); #1;
        cyc = c;
        if (c == 1) check("len0_done", 32'(boot_done0), 1);
        if (cpu_ack) early_ack++;
        if (boot_done || boot_error) break;
      end
      copied = (exc_byte < int'(LEN)) ? exc_byte : int'(LEN);
      exp_sum = 32'h0;
      for (int i = 0; i < copied; i++) begin
        ref_ram[i] = flash_mem[i];
        exp_sum += 32'(flash_mem[i]);
      end
      for (int i = 0; i < 8; i++) check("ram_byte", 32'(ram_mem[i]), 32'(ref_ram[i]));
      check("copy_count", 32'(copy_count), 32'(copied));
`ifdef BOOT_CHECKSUM_EN
      check("boot_sum", boot_sum, exp_sum);
`endif

      if (exc_byte < int'(LEN)) begin
        check("err_cycles", cyc, 3 * exc_byte + 2);
        check("err_flag", 32'(boot_error), 1);
        check("err_done", 32'(boot_done), 0);
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_len = 2'b00; cpu_addr = DST;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          if (cpu_ack) acks++;
        end
        check("err_no_ack", acks, 0);
        check("err_sticky", 32'(boot_error), 1);
        cpu_req = 1'b0;
      end else begin
        check("done_cycles", cyc, 3 * int'(LEN));
        check("done_flag", 32'(boot_done), 1);
        check("done_no_err", 32'(boot_error), 0);
        if (r == 2) begin
          check("held_no_early_ack", early_ack, 0);
          lat = 0;
          for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            lat = n;
            if (cpu_ack) break;
          end
          check("held_ack_latency", lat, 2);
          check("held_rdata", cpu_rdata, ref_word(DST + 32'd2));
          cpu_req = 1'b0;
        end
        if (r == 0) begin
          cpu_op(1'b0, 2'd0, DST + 32'd2, 32'h0);
          check("plan_read_byte", 32'(cpu_rdata[7:0]), 32'(flash_mem[2]));
          cpu_req0 = 1'b1;
          lat = 0;
          for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            lat = n;
            if (cpu_ack0) break;
          end
          check("len0_latency", lat, 2);
          check("len0_rdata", cpu_rdata0, 32'hC0DE_0042);
          cpu_req0 = 1'b0;
          check("len0_no_write", rw0_cnt, 0);
        end
        for (int k = 0; k < 8; k++) begin
          sel = int'($urandom_range(0, 3));
          if (sel == 0) cpu_op(1'b0, 2'($urandom_range(0, 2)), SRC + 32'($urandom_range(0, 7)), 32'h0);
          else if (sel == 1) cpu_op(1'b0, 2'd2, EXC_RAM, 32'h0);
          else cpu_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                      DST + 32'($urandom_range(0, 63)), $urandom);
        end
        check("cpu_exc_no_berr", 32'(boot_error), 0);
`ifdef BOOT_CHECKSUM_EN
        check("sum_frozen", boot_sum, exp_sum);
`endif
      end

      cpu_req = 1'b1; cpu_rw = 1'b0; cpu_len = 2'b00; cpu_addr = DST;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_reset("rst_mid");
      cpu_req = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
